// File: rtl/instr_pkg.sv
// Shared types for the instruction issue controller: instruction classes, FSM states,
// ARM condition-code constants and the condition evaluation function.
package instr_pkg;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_DP   = 3'd1,
        CLS_MUL  = 3'd2,
        CLS_MEM  = 3'd3,
        CLS_BR   = 3'd4,
        CLS_UND  = 3'd5
    } cls_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_MULW = 3'd2,
        ST_MEMW = 3'd3,
        ST_BRW  = 3'd4
    } state_t;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // NV returns pass; the caller reclassifies it as undefined instead of skipping it.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic res;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational ARM instruction-class decoder; multiply is checked first because its
// encoding overlaps the data-processing space.
module instr_class_decode
    import instr_pkg::*;
(
    input  logic [31:0] instr_i,
    output cls_t        cls_o
);

    logic unused_bits;
    assign unused_bits = ^{instr_i[31:28], instr_i[21:8], instr_i[3:0]};

    always_comb begin
        cls_o = CLS_UND;
        if (instr_i[27:22] == 6'b000000 && instr_i[7:4] == 4'b1001) begin
            cls_o = CLS_MUL;
        end else if (instr_i[27:26] == 2'b00) begin
            cls_o = CLS_DP;
        end else if (instr_i[27:26] == 2'b01) begin
            cls_o = CLS_MEM;
        end else if (instr_i[27:25] == 3'b101) begin
            cls_o = CLS_BR;
        end
    end

endmodule

// File: rtl/instr_issue_ctrl.sv
// Single-issue sequencer: accepts one instruction, drives the matching execute unit and
// pulses done on retire. Optional condition-code gating is enabled by COND_CHECK_EN.
module instr_issue_ctrl
    import instr_pkg::*;
#(
    parameter int MUL_LAT     = 3,
    parameter int BR_PENALTY  = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    input  logic [3:0]  flags_nzcv,
    output logic        alu_start,
    output logic        mul_start,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        flush,
    output cls_t        cls,
    output logic        done,
    output logic        err
);

    localparam int MW = $clog2(MUL_LAT + 1);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam int BW = (BR_PENALTY > 0) ? $clog2(BR_PENALTY + 1) : 1;

    state_t        state_q, state_d;
    cls_t          cls_q, cls_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic          skip_q, skip_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    cls_t dec_cls;
    cls_t acc_cls;
    logic acc_skip;

    instr_class_decode u_decode (
        .instr_i (instruction),
        .cls_o   (dec_cls)
    );

`ifdef COND_CHECK_EN
    assign acc_cls  = (instruction[31:28] == COND_NV) ? CLS_UND : dec_cls;
    assign acc_skip = ~cond_pass(instruction[31:28], flags_nzcv);
`else
    logic unused_flags;
    assign unused_flags = ^flags_nzcv;
    assign acc_cls  = dec_cls;
    assign acc_skip = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_NONE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            skip_q  <= 1'b0;
            mcnt_q  <= '0;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            we_q    <= we_d;
            err_q   <= err_d;
            skip_q  <= skip_d;
            mcnt_q  <= mcnt_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        we_d    = we_q;
        err_d   = err_q;
        skip_d  = skip_q;
        mcnt_d  = mcnt_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cls_d  = acc_cls;
                    we_d   = ~instruction[20];
                    skip_d = acc_skip;
                    err_d  = (acc_cls == CLS_UND) && !acc_skip;
                    mcnt_d = MW'(1);
                    tcnt_d = TW'(1);
                    bcnt_d = '0;
                    if (acc_skip) begin
                        state_d = ST_EXEC;
                    end else begin
                        case (acc_cls)
                            CLS_MUL: state_d = ST_MULW;
                            CLS_MEM: state_d = ST_MEMW;
                            CLS_BR:  state_d = ST_BRW;
                            default: state_d = ST_EXEC;
                        endcase
                    end
                end
            end
            ST_EXEC: state_d = ST_IDLE;
            ST_MULW: begin
                if (mcnt_q == MW'(MUL_LAT)) state_d = ST_IDLE;
                else                        mcnt_d  = mcnt_q + MW'(1);
            end
            // Ack wins over a timeout expiring in the same cycle; both retire through EXEC.
            ST_MEMW: begin
                if (mem_ack) begin
                    state_d = ST_EXEC;
                    err_d   = 1'b0;
                end else if (tcnt_q == TW'(MEM_TIMEOUT)) begin
                    state_d = ST_EXEC;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d  = tcnt_q + TW'(1);
                end
            end
            ST_BRW: begin
                if (bcnt_q == BW'(BR_PENALTY)) state_d = ST_IDLE;
                else                           bcnt_d  = bcnt_q + BW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        alu_start = (state_q == ST_EXEC) && (cls_q == CLS_DP) && !skip_q;
        mul_start = (state_q == ST_MULW) && (mcnt_q == MW'(1));
        mem_req   = (state_q == ST_MEMW);
        mem_we    = (state_q == ST_MEMW) && we_q;
        flush     = (state_q == ST_BRW) && (bcnt_q == '0);
        done      = (state_q == ST_EXEC)
                 || ((state_q == ST_MULW) && (mcnt_q == MW'(MUL_LAT)))
                 || ((state_q == ST_BRW) && (bcnt_q == BW'(BR_PENALTY)));
        err       = (state_q == ST_EXEC) && err_q;
        cls       = (state_q == ST_IDLE) ? CLS_NONE : cls_q;
    end

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Directed bench for instr_issue_ctrl with default parameters (MUL_LAT=3, BR_PENALTY=2,
// MEM_TIMEOUT=15); condition-gating steps follow COND_CHECK_EN.
module tb_instr_issue_ctrl;
    import instr_pkg::*;

    localparam logic [7:0] RDY = 8'h80;
    localparam logic [7:0] ALU = 8'h40;
    localparam logic [7:0] MUL = 8'h20;
    localparam logic [7:0] REQ = 8'h10;
    localparam logic [7:0] WE  = 8'h08;
    localparam logic [7:0] FL  = 8'h04;
    localparam logic [7:0] DN  = 8'h02;
    localparam logic [7:0] ER  = 8'h01;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [3:0]  flags_nzcv;
    logic        alu_start;
    logic        mul_start;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        flush;
    cls_t        cls;
    logic        done;
    logic        err;

    logic [7:0]  outs;
    int          tests;
    int          fails;

    assign outs = {in_ready, alu_start, mul_start, mem_req, mem_we, flush, done, err};

    instr_issue_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .flags_nzcv  (flags_nzcv),
        .alu_start   (alu_start),
        .mul_start   (mul_start),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .flush       (flush),
        .cls         (cls),
        .done        (done),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; samples mid-cycle and returns just after the next edge.
    task automatic cyc(input string tag, input logic [7:0] eo, input cls_t ec);
        @(negedge clock);
        check({tag, " outs"}, {24'h0, outs}, {24'h0, eo});
        check({tag, " cls"}, {29'h0, cls}, {29'h0, ec});
        @(posedge clock);
        #1;
    endtask

    task automatic cyc_o(input string tag, input logic [7:0] eo);
        @(negedge clock);
        check({tag, " outs"}, {24'h0, outs}, {24'h0, eo});
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] w);
        instruction = w;
        in_valid    = 1'b1;
        @(posedge clock);
        #1;
        in_valid    = 1'b0;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        instruction = 32'h0;
        flags_nzcv  = 4'b0000;
        mem_ack     = 1'b0;

        // Reset state, then a data-processing op
        repeat (2) @(posedge clock);
        #1;
        cyc("reset", RDY, CLS_NONE);
        reset_n = 1'b1;
        cyc("idle", RDY, CLS_NONE);
        issue(32'hE0810002);
        cyc("dp k+1", ALU | DN, CLS_DP);
        cyc("dp k+2", RDY, CLS_NONE);

        // Multiply
        issue(32'hE0000291);
        cyc("mul k+1", MUL, CLS_MUL);
        cyc("mul k+2", 8'h00, CLS_MUL);
        cyc("mul k+3", DN, CLS_MUL);
        cyc("mul k+4", RDY, CLS_NONE);

        // Ack while idle is ignored
        mem_ack = 1'b1;
        cyc("ack idle", RDY, CLS_NONE);
        mem_ack = 1'b0;

        // Load, ack in fourth request cycle
        issue(32'hE5910000);
        for (int i = 1; i <= 3; i++) cyc($sformatf("ldr c%0d", i), REQ, CLS_MEM);
        mem_ack = 1'b1;
        cyc("ldr c4", REQ, CLS_MEM);
        mem_ack = 1'b0;
        cyc("ldr done", DN, CLS_MEM);
        cyc("ldr idle", RDY, CLS_NONE);

        // Store, immediate ack
        issue(32'hE5810000);
        mem_ack = 1'b1;
        cyc("str c1", REQ | WE, CLS_MEM);
        mem_ack = 1'b0;
        cyc("str done", DN, CLS_MEM);
        cyc("str idle", RDY, CLS_NONE);

        // Memory timeout
        issue(32'hE5910000);
        for (int i = 1; i <= 15; i++) cyc($sformatf("tmo c%0d", i), REQ, CLS_MEM);
        cyc("tmo done", DN | ER, CLS_MEM);
        cyc("tmo idle", RDY, CLS_NONE);

        // Ack in the expiring cycle wins
        issue(32'hE5910000);
        for (int i = 1; i <= 14; i++) cyc($sformatf("late c%0d", i), REQ, CLS_MEM);
        mem_ack = 1'b1;
        cyc("late c15", REQ, CLS_MEM);
        mem_ack = 1'b0;
        cyc("late done", DN, CLS_MEM);
        cyc("late idle", RDY, CLS_NONE);

        // Branch
        issue(32'hEA000010);
        cyc("b k+1", FL, CLS_BR);
        cyc("b k+2", 8'h00, CLS_BR);
        cyc("b k+3", DN, CLS_BR);
        cyc("b k+4", RDY, CLS_NONE);

        // Undefined
        issue(32'hEE000000);
        cyc("und k+1", DN | ER, CLS_UND);
        cyc("und k+2", RDY, CLS_NONE);

        // Conditional branch, Z clear
        flags_nzcv = 4'b0000;
        issue(32'h0A000004);
`ifdef COND_CHECK_EN
        cyc_o("beq nz k+1", DN);
        cyc("beq nz k+2", RDY, CLS_NONE);
`else
        cyc("beq nz k+1", FL, CLS_BR);
        cyc("beq nz k+2", 8'h00, CLS_BR);
        cyc("beq nz k+3", DN, CLS_BR);
        cyc("beq nz k+4", RDY, CLS_NONE);
`endif

        // Conditional branch, Z set
        flags_nzcv = 4'b0100;
        issue(32'h0A000004);
        flags_nzcv = 4'b0000;
        cyc("beq z k+1", FL, CLS_BR);
        cyc("beq z k+2", 8'h00, CLS_BR);
        cyc("beq z k+3", DN, CLS_BR);
        cyc("beq z k+4", RDY, CLS_NONE);

        // Condition field 1111
        issue(32'hFA000000);
`ifdef COND_CHECK_EN
        cyc("nv k+1", DN | ER, CLS_UND);
        cyc("nv k+2", RDY, CLS_NONE);
`else
        cyc("nv k+1", FL, CLS_BR);
        cyc("nv k+2", 8'h00, CLS_BR);
        cyc("nv k+3", DN, CLS_BR);
        cyc("nv k+4", RDY, CLS_NONE);
`endif

        // Reset in the middle of a memory wait
        issue(32'hE5910000);
        cyc("rst c1", REQ, CLS_MEM);
        cyc("rst c2", REQ, CLS_MEM);
        reset_n = 1'b0;
        cyc("rst held", RDY, CLS_NONE);
        reset_n = 1'b1;
        cyc("rst rel1", RDY, CLS_NONE);
        cyc("rst rel2", RDY, CLS_NONE);
        issue(32'hE0810002);
        cyc("post dp k+1", ALU | DN, CLS_DP);
        cyc("post dp k+2", RDY, CLS_NONE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
